// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for the UART RX engine.
// Gates the engine with en_rx, captures each completed frame on the rising edge
// of rx_done, and queues the bytes in a DEPTH-entry FIFO that the bus side drains
// through rd_valid/rd_ready. A watchdog resynchronises the engine when a frame
// stalls. Overflow and timeout are reported as sticky flags.
// Optional build macro UART_RX_CTRL_STATS_EN adds the stat_bytes/stat_drops counters.
module uart_rx_ctrl #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ctrl_enable,
   input  logic                     rx_line,
   input  logic                     rx_done,
   input  logic [7:0]               rx_data,
   output logic                     en_rx,
   output logic                     rd_valid,
   output logic [7:0]               rd_data,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
`ifdef UART_RX_CTRL_STATS_EN
   output logic [15:0]              stat_bytes,
   output logic [15:0]              stat_drops,
`endif
   output logic                     err_overflow,
   output logic                     err_timeout,
   input  logic                     err_clr
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC) + 1;

   // REC1/REC2 together form the two-cycle recovery window with the engine off.
   typedef enum logic [2:0] {
      S_DISABLED,
      S_ARM,
      S_WAIT,
      S_CAPTURE,
      S_REC1,
      S_REC2
   } state_t;

   state_t             state_q, state_d;
   logic               rx_done_prev_q, rx_done_prev_d;
   logic [7:0]         cap_data_q, cap_data_d;
   logic               wd_run_q, wd_run_d;
   logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_nx;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [7:0]         rd_data_q, rd_data_d;
   logic               err_overflow_q, err_overflow_d;
   logic               err_timeout_q, err_timeout_d;
   logic [7:0]         mem_q [DEPTH];

   logic               rx_rise;
   logic               push;
   logic               timeout_set;
   logic               fifo_empty;
   logic               fifo_full;
   logic               pop;
   logic               do_push;
   logic               drop;

   // Control FSM: next state and the engine enable, decoded from the current state.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a
      // signal unassigned and no latch is inferred.
      state_d     = state_q;
      en_rx       = 1'b0;
      push        = 1'b0;
      timeout_set = 1'b0;
      rx_rise     = (state_q == S_WAIT) && rx_done && !rx_done_prev_q;
      unique case (state_q)
         S_DISABLED: begin
            if (ctrl_enable) state_d = S_ARM;
         end
         S_ARM: begin
            en_rx   = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            en_rx = 1'b1;
            if (rx_rise) begin
               state_d = S_CAPTURE;
            end else if (wd_run_q && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1))) begin
               state_d = S_REC1;
            end
         end
         S_CAPTURE: begin
            en_rx   = 1'b1;
            push    = 1'b1;
            state_d = S_ARM;
         end
         S_REC1: begin
            timeout_set = 1'b1;
            state_d     = S_REC2;
         end
         S_REC2: begin
            state_d = S_ARM;
         end
         default: state_d = S_DISABLED;
      endcase
      // Dropping the enable wins from every state; a partial frame is abandoned.
      if (!ctrl_enable) state_d = S_DISABLED;
   end

   // Edge detector, capture register, watchdog, FIFO bookkeeping and sticky flags.
   always_comb begin
      rx_done_prev_d = (state_q == S_DISABLED || state_q == S_REC1 || state_q == S_REC2)
                       ? 1'b0 : rx_done;
      cap_data_d     = rx_rise ? rx_data : cap_data_q;

      // The watchdog only runs in WAIT, armed by the start-bit fall on rx_line.
      wd_run_d = wd_run_q;
      wd_cnt_d = wd_cnt_q;
      if (state_q == S_ARM || state_q == S_DISABLED || rx_rise) begin
         wd_run_d = 1'b0;
         wd_cnt_d = '0;
      end else if (state_q == S_WAIT) begin
         if (wd_run_q) begin
            if (wd_cnt_q != '1) wd_cnt_d = wd_cnt_q + WD_W'(1);
         end else if (!rx_line) begin
            wd_run_d = 1'b1;
         end
      end

      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == CNT_W'(DEPTH));
      pop        = !fifo_empty && rd_ready;
      do_push    = push && (!fifo_full || pop);
      drop       = push && fifo_full && !pop;
      rd_ptr_nx  = rd_ptr_q + PTR_W'(1);

      wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_nx : rd_ptr_q;
      unique case ({do_push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // The head register follows the FIFO: a push into an empty FIFO loads the
      // pushed byte directly; a pop loads the next entry, or the byte being pushed
      // when that next entry is the one being written this cycle.
      rd_data_d = rd_data_q;
      if (do_push && fifo_empty) begin
         rd_data_d = cap_data_q;
      end else if (pop) begin
         if (count_q == CNT_W'(1)) begin
            if (do_push) rd_data_d = cap_data_q;
         end else begin
            rd_data_d = mem_q[rd_ptr_nx];
         end
      end

      // A set event in the same cycle as err_clr leaves the flag set.
      err_overflow_d = drop || (err_overflow_q && !err_clr);
      err_timeout_d  = timeout_set || (err_timeout_q && !err_clr);
   end

   // State and control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is written with non-blocking assignments only, so
      // every flop samples the values from before the edge.
      if (!rst_n) begin
         state_q        <= S_DISABLED;
         rx_done_prev_q <= 1'b0;
         cap_data_q     <= 8'h00;
         wd_run_q       <= 1'b0;
         wd_cnt_q       <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         rd_data_q      <= 8'h00;
         err_overflow_q <= 1'b0;
         err_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         rx_done_prev_q <= rx_done_prev_d;
         cap_data_q     <= cap_data_d;
         wd_run_q       <= wd_run_d;
         wd_cnt_q       <= wd_cnt_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         rd_data_q      <= rd_data_d;
         err_overflow_q <= err_overflow_d;
         err_timeout_q  <= err_timeout_d;
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; the pointers, count and head register
      // are reset, so an entry is never observed before it has been written.
      if (do_push) mem_q[wr_ptr_q] <= cap_data_q;
   end

`ifdef UART_RX_CTRL_STATS_EN
   logic [15:0] stat_bytes_q, stat_bytes_d;
   logic [15:0] stat_drops_q, stat_drops_d;

   // Saturating statistics; a counted event in the same cycle as err_clr still counts.
   always_comb begin
      stat_bytes_d = stat_bytes_q;
      stat_drops_d = stat_drops_q;
      if (do_push) begin
         if (stat_bytes_q != 16'hFFFF) stat_bytes_d = stat_bytes_q + 16'd1;
      end else if (err_clr) begin
         stat_bytes_d = 16'h0000;
      end
      if (drop) begin
         if (stat_drops_q != 16'hFFFF) stat_drops_d = stat_drops_q + 16'd1;
      end else if (err_clr) begin
         stat_drops_d = 16'h0000;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_bytes_q <= 16'h0000;
         stat_drops_q <= 16'h0000;
      end else begin
         stat_bytes_q <= stat_bytes_d;
         stat_drops_q <= stat_drops_d;
      end
   end

   assign stat_bytes = stat_bytes_q;
   assign stat_drops = stat_drops_q;
`endif

   assign rd_valid     = !fifo_empty;
   assign rd_data      = rd_data_q;
   assign fifo_count   = count_q;
   assign err_overflow = err_overflow_q;
   assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl (DEPTH=8, TIMEOUT_CYC=64).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_rx_ctrl;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ctrl_enable;
   logic        rx_line;
   logic        rx_done;
   logic [7:0]  rx_data;
   logic        en_rx;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        rd_ready;
   logic [3:0]  fifo_count;
   logic        err_overflow;
   logic        err_timeout;
   logic        err_clr;
`ifdef UART_RX_CTRL_STATS_EN
   logic [15:0] stat_bytes;
   logic [15:0] stat_drops;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ctrl_enable  (ctrl_enable),
      .rx_line      (rx_line),
      .rx_done      (rx_done),
      .rx_data      (rx_data),
      .en_rx        (en_rx),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_ready     (rd_ready),
      .fifo_count   (fifo_count),
`ifdef UART_RX_CTRL_STATS_EN
      .stat_bytes   (stat_bytes),
      .stat_drops   (stat_drops),
`endif
      .err_overflow (err_overflow),
      .err_timeout  (err_timeout),
      .err_clr      (err_clr)
   );

   typedef struct {
      logic [7:0] data;
      logic       rdy;
      logic       clr;
      logic       clr_after;
      int         exp_count;
      logic       exp_ovf;
      logic [7:0] exp_head;
      int         exp_drops;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One frame: start bit low for four cycles, rx_done high for one cycle with the
   // byte, then rd_ready/err_clr applied on the capture cycle. Returns at the edge
   // where the push has landed; mid_valid is rd_valid one cycle after the rx_done edge.
   task automatic send_frame(input logic [7:0] d, input logic rdy, input logic clr,
                             output logic mid_valid);
      rx_line = 1'b0;
      repeat (4) @(negedge clk);
      rx_done = 1'b1;
      rx_data = d;
      rx_line = 1'b1;
      @(negedge clk);
      mid_valid = rd_valid;
      rx_done   = 1'b0;
      rx_data   = 8'h00;
      rd_ready  = rdy;
      err_clr   = clr;
      @(negedge clk);
      rd_ready = 1'b0;
      err_clr  = 1'b0;
   endtask

   task automatic drain(input string name, input logic [7:0] exp [$]);
      rd_ready = 1'b1;
      foreach (exp[k]) begin
         check({name, " valid"}, 32'(rd_valid), 32'd1);
         check({name, " data"}, 32'(rd_data), 32'(exp[k]));
         @(negedge clk);
      end
      rd_ready = 1'b0;
      check({name, " empty count"}, 32'(fifo_count), 32'd0);
      check({name, " empty valid"}, 32'(rd_valid), 32'd0);
   endtask

   initial begin
      logic mid;
      logic [7:0] exp_q [$];

      // Overflow scenario: eight fills, two drops (the second with err_clr on the
      // same cycle), a clear on its own, then a push that coincides with a pop.
      for (int i = 0; i < 8; i++)
         vecs[i] = '{8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, i + 1, 1'b0, 8'h10, 0};
      vecs[8]  = '{8'h18, 1'b0, 1'b0, 1'b0, 8, 1'b1, 8'h10, 1};
      vecs[9]  = '{8'h19, 1'b0, 1'b1, 1'b1, 8, 1'b1, 8'h10, 2};
      vecs[10] = '{8'hEE, 1'b1, 1'b0, 1'b0, 8, 1'b0, 8'h11, 0};

      rst_n       = 1'b0;
      ctrl_enable = 1'b1;
      rx_line     = 1'b1;
      rx_done     = 1'b0;
      rx_data     = 8'h00;
      rd_ready    = 1'b0;
      err_clr     = 1'b0;

      // Reset held with ctrl_enable high.
      repeat (3) @(negedge clk);
      check("reset en_rx", 32'(en_rx), 32'd0);
      check("reset rd_valid", 32'(rd_valid), 32'd0);
      check("reset rd_data", 32'(rd_data), 32'd0);
      check("reset count", 32'(fifo_count), 32'd0);
      check("reset err_overflow", 32'(err_overflow), 32'd0);
      check("reset err_timeout", 32'(err_timeout), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("arm after release", 32'(en_rx), 32'd1);
      @(negedge clk);
      check("wait en_rx", 32'(en_rx), 32'd1);

      // Three frames queued without popping, then drained in order.
      send_frame(8'hA5, 1'b0, 1'b0, mid);
      check("latency N+1 valid", 32'(mid), 32'd0);
      check("latency N+2 valid", 32'(rd_valid), 32'd1);
      check("first head", 32'(rd_data), 32'hA5);
      send_frame(8'h3C, 1'b0, 1'b0, mid);
      send_frame(8'hFF, 1'b0, 1'b0, mid);
      check("three frames count", 32'(fifo_count), 32'd3);
      exp_q = '{8'hA5, 8'h3C, 8'hFF};
      drain("drain3", exp_q);

      // Overflow table.
      for (int i = 0; i < 11; i++) begin
         send_frame(vecs[i].data, vecs[i].rdy, vecs[i].clr, mid);
         check($sformatf("vec%0d count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d overflow", i), 32'(err_overflow), 32'(vecs[i].exp_ovf));
         check($sformatf("vec%0d head", i), 32'(rd_data), 32'(vecs[i].exp_head));
`ifdef UART_RX_CTRL_STATS_EN
         check($sformatf("vec%0d drops", i), 32'(stat_drops), 32'(vecs[i].exp_drops));
`endif
         if (vecs[i].clr_after) begin
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            check($sformatf("vec%0d clr alone", i), 32'(err_overflow), 32'd0);
`ifdef UART_RX_CTRL_STATS_EN
            check($sformatf("vec%0d drops clr", i), 32'(stat_drops), 32'd0);
`endif
         end
      end
      exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hEE};
      drain("drain8", exp_q);

      // Stalled frame: line low, rx_done never rises.
      rx_line = 1'b0;
      repeat (TIMEOUT) @(negedge clk);
      check("timeout last wait en_rx", 32'(en_rx), 32'd1);
      check("timeout flag before", 32'(err_timeout), 32'd0);
      @(negedge clk);
      check("recover cycle1 en_rx", 32'(en_rx), 32'd0);
      @(negedge clk);
      check("recover cycle2 en_rx", 32'(en_rx), 32'd0);
      check("timeout flag set", 32'(err_timeout), 32'd1);
      rx_line = 1'b1;
      @(negedge clk);
      check("rearm after recover", 32'(en_rx), 32'd1);
      @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b0, mid);
      check("post-timeout count", 32'(fifo_count), 32'd1);
      check("post-timeout data", 32'(rd_data), 32'h5A);
      check("timeout sticky", 32'(err_timeout), 32'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("timeout cleared", 32'(err_timeout), 32'd0);

      // Enable dropped mid-frame; the late rx_done must not push.
      rx_line = 1'b0;
      repeat (3) @(negedge clk);
      ctrl_enable = 1'b0;
      @(negedge clk);
      check("disable en_rx", 32'(en_rx), 32'd0);
      rx_done = 1'b1;
      rx_data = 8'h77;
      @(negedge clk);
      rx_done = 1'b0;
      rx_line = 1'b1;
      repeat (2) @(negedge clk);
      check("disabled no push", 32'(fifo_count), 32'd1);
      check("disabled en_rx held", 32'(en_rx), 32'd0);
      exp_q = '{8'h5A};
      drain("drain disabled", exp_q);

      // rx_done already high when receive is re-enabled is not a frame edge.
      rx_done = 1'b1;
      rx_data = 8'h99;
      ctrl_enable = 1'b1;
      repeat (5) @(negedge clk);
      check("held rx_done no edge", 32'(fifo_count), 32'd0);
      check("re-enabled en_rx", 32'(en_rx), 32'd1);
      rx_done = 1'b0;
      @(negedge clk);
      send_frame(8'hC3, 1'b0, 1'b0, mid);
      check("frame after held", 32'(fifo_count), 32'd1);
      check("frame after held data", 32'(rd_data), 32'hC3);
      check("final overflow", 32'(err_overflow), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
